// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/D memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    // Wide enough for any practical DATA_W; users slice the low DATA_W/8 bits.
    localparam int MAX_BE_W = 128;
    localparam logic [MAX_BE_W-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + CNT_W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port SRAM between fetch (IF) and data (D) ports.
// Build option: MEM_ARB_RR_EN selects round-robin; default is fixed D-over-IF priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]    conflict_cnt
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0] BE_ONES = BE_ALL_ONES[BE_W-1:0];

    owner_e r_last_owner;
    owner_e r_resp_owner;
    logic   r_resp_valid;
    logic   w_d_wins;
    logic   w_conflict;

    assign w_conflict = if_req & d_req;

`ifdef MEM_ARB_RR_EN
    // On a conflict the port that did not own the last grant goes next.
    assign w_d_wins = d_req & (~if_req | (r_last_owner == OWN_IF));
`else
    assign w_d_wins = d_req;
`endif

    assign d_gnt  = ~rst & w_d_wins;
    assign if_gnt = ~rst & if_req & ~w_d_wins;

    assign mem_en    = if_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_be    = (d_gnt && d_we) ? d_be : BE_ONES;
    assign mem_addr  = d_gnt ? d_addr : if_addr;
    assign mem_wdata = d_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_owner <= OWN_IF;
            r_resp_valid <= 1'b0;
            r_resp_owner <= OWN_IF;
        end else begin
            r_resp_valid <= mem_en;
            if (mem_en) begin
                r_resp_owner <= d_gnt ? OWN_D : OWN_IF;
                r_last_owner <= d_gnt ? OWN_D : OWN_IF;
            end
        end
    end

    // Read data needs no register: the SRAM output is already one cycle behind the grant.
    assign if_rvalid = ~rst & r_resp_valid & (r_resp_owner == OWN_IF);
    assign d_rvalid  = ~rst & r_resp_valid & (r_resp_owner == OWN_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_conflict_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_conflict),
        .i_clear (1'b0),
        .o_count (conflict_cnt)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; a second instance with CNT_W=4 checks counter saturation.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [BW-1:0] d_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;

    logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] if_rdata, d_rdata;
    logic          mem_en, mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   conflict_cnt;

    logic          s_if_gnt, s_if_rvalid, s_d_gnt, s_d_rvalid, s_mem_en, s_mem_we;
    logic [DW-1:0] s_if_rdata, s_d_rdata, s_mem_wdata;
    logic [BW-1:0] s_mem_be;
    logic [AW-1:0] s_mem_addr;
    logic [3:0]    s_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic          own_d;
        logic          chk;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] r_sram_q;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(s_if_gnt),
        .if_rvalid(s_if_rvalid), .if_rdata(s_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_be(s_mem_be), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_rdata(32'h0), .conflict_cnt(s_cnt)
    );

    // Behavioural single-port SRAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                r_sram_q <= sram[mem_addr];
            end
        end
    end
    assign mem_rdata = r_sram_q;

    // Response monitor: every rvalid must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            n_chk++;
            if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0)
                $display("FAIL rvalid_in_reset: if_rvalid=%b d_rvalid=%b required 0/0", if_rvalid, d_rvalid);
            else
                n_pass++;
        end else if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_rvalid: if_rvalid=%b d_rvalid=%b required none", if_rvalid, d_rvalid);
            end else begin
                e = exp_q.pop_front();
                if (d_rvalid !== e.own_d || if_rvalid !== !e.own_d)
                    $display("FAIL resp_owner: if_rvalid=%b d_rvalid=%b required d_rvalid=%b", if_rvalid, d_rvalid, e.own_d);
                else if (e.chk && ((e.own_d ? d_rdata : if_rdata) !== e.data))
                    $display("FAIL resp_data: got %h required %h", e.own_d ? d_rdata : if_rdata, e.data);
                else
                    n_pass++;
            end
        end
    end

    function automatic logic exp_d_on_conflict(input int i);
`ifdef MEM_ARB_RR_EN
        return (i % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic idle(input int n);
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        if_req = 1'b0;
        d_req  = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
    endtask

    task automatic test_reset();
        if_req = 1'b1;
        d_req  = 1'b1;
        @(negedge clk);
        n_chk++;
        if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0)
            $display("FAIL reset_gnt: if_gnt=%b d_gnt=%b mem_en=%b required 0/0/0", if_gnt, d_gnt, mem_en);
        else n_pass++;
        n_chk++;
        if (conflict_cnt !== 16'd0)
            $display("FAIL reset_cnt: got %0d required 0", conflict_cnt);
        else n_pass++;
        @(posedge clk); #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        rst    = 1'b0;
        idle(1);
    endtask

    task automatic test_if_stream();
        for (int k = 0; k < 3; k++) begin
            if_req  = 1'b1;
            if_addr = AW'(k);
            exp_q.push_back('{own_d: 1'b0, chk: 1'b1, data: 32'h11 * (k + 1)});
            @(negedge clk);
            n_chk++;
            if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== AW'(k) || mem_we !== 1'b0 || mem_be !== 4'hF)
                $display("FAIL if_stream_gnt: if_gnt=%b d_gnt=%b addr=%0d we=%b be=%h required 1/0/%0d/0/f",
                         if_gnt, d_gnt, mem_addr, mem_we, mem_be, k);
            else n_pass++;
            @(posedge clk); #1;
        end
        idle(2);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL if_stream_drain: %0d pending required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 12'd5; d_wdata = 32'hDEADBEEF;
        exp_q.push_back('{own_d: 1'b1, chk: 1'b0, data: '0});
        @(negedge clk);
        n_chk++;
        if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'hDEADBEEF)
            $display("FAIL store_drive: gnt=%b en=%b we=%b be=%b wdata=%h required 1/1/1/0011/deadbeef",
                     d_gnt, mem_en, mem_we, mem_be, mem_wdata);
        else n_pass++;
        @(posedge clk); #1;
        d_we = 1'b0; d_be = 4'b0000;
        exp_q.push_back('{own_d: 1'b1, chk: 1'b1, data: 32'h0000BEEF});
        @(negedge clk);
        n_chk++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF)
            $display("FAIL load_drive: gnt=%b we=%b be=%h required 1/0/f", d_gnt, mem_we, mem_be);
        else n_pass++;
        @(posedge clk); #1;
        // Store with no byte lanes is still issued and acknowledged.
        d_we = 1'b1; d_be = 4'b0000; d_addr = 12'd6; d_wdata = 32'hFFFFFFFF;
        exp_q.push_back('{own_d: 1'b1, chk: 1'b0, data: '0});
        @(negedge clk);
        n_chk++;
        if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_be !== 4'h0)
            $display("FAIL store_be0: gnt=%b en=%b be=%h required 1/1/0", d_gnt, mem_en, mem_be);
        else n_pass++;
        @(posedge clk); #1;
        idle(2);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL store_load_drain: %0d pending required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_conflict();
        logic ed;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            ed = exp_d_on_conflict(i);
            if_req = 1'b1; if_addr = 12'd0;
            d_req  = 1'b1; d_we = 1'b0; d_addr = 12'd1;
            exp_q.push_back('{own_d: ed, chk: 1'b1, data: ed ? 32'h22 : 32'h11});
            @(negedge clk);
            n_chk++;
            if (d_gnt !== ed || if_gnt !== !ed)
                $display("FAIL conflict_gnt[%0d]: d_gnt=%b if_gnt=%b required %b/%b", i, d_gnt, if_gnt, ed, !ed);
            else n_pass++;
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_chk++;
        if (conflict_cnt !== 16'd4) $display("FAIL conflict_cnt: got %0d required 4", conflict_cnt);
        else n_pass++;
        @(posedge clk); #1;
        idle(1);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL conflict_drain: %0d pending required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'd0;
        @(negedge clk);
        n_chk++;
        if (d_gnt !== 1'b1) $display("FAIL midrst_load_gnt: got %b required 1", d_gnt);
        else n_pass++;
        @(posedge clk); #1;
        d_req = 1'b0; rst = 1'b1;
        if_req = 1'b1; if_addr = 12'd1;
        @(negedge clk);
        n_chk++;
        if (if_gnt !== 1'b0 || mem_en !== 1'b0 || conflict_cnt !== 16'd0)
            $display("FAIL midrst_forced: if_gnt=%b mem_en=%b cnt=%0d required 0/0/0", if_gnt, mem_en, conflict_cnt);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back('{own_d: 1'b0, chk: 1'b1, data: 32'h22});
        @(negedge clk);
        n_chk++;
        if (if_gnt !== 1'b1 || d_rvalid !== 1'b0)
            $display("FAIL midrst_after: if_gnt=%b d_rvalid=%b required 1/0", if_gnt, d_rvalid);
        else n_pass++;
        @(posedge clk); #1;
        idle(2);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL midrst_drain: %0d pending required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic ed;
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            ed = exp_d_on_conflict(i);
            if_req = 1'b1; if_addr = 12'd2;
            d_req  = 1'b1; d_we = 1'b0; d_addr = 12'd0;
            exp_q.push_back('{own_d: ed, chk: 1'b1, data: ed ? 32'h11 : 32'h33});
            @(negedge clk);
            n_chk++;
            if (s_cnt !== 4'((i < 15) ? i : 15) || conflict_cnt !== 16'(i))
                $display("FAIL sat_cnt[%0d]: cnt4=%0d cnt16=%0d required %0d/%0d",
                         i, s_cnt, conflict_cnt, (i < 15) ? i : 15, i);
            else n_pass++;
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_chk++;
        if (s_cnt !== 4'd15 || conflict_cnt !== 16'd20)
            $display("FAIL sat_final: cnt4=%0d cnt16=%0d required 15/20", s_cnt, conflict_cnt);
        else n_pass++;
        @(posedge clk); #1;
        idle(2);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL sat_drain: %0d pending required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) sram[a] = '0;
        sram[0] = 32'h11;
        sram[1] = 32'h22;
        sram[2] = 32'h33;
        r_sram_q = '0;
        #1;
        test_reset();
        test_if_stream();
        test_store_load();
        test_conflict();
        test_reset_mid_access();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
